// File: rtl/multicycle_ctrl_if.sv
// Purpose: groups the run request, instruction-fetch and register-file control
//          signals of the multicycle controller into one bundle.
// Ports: start/imem_rdata/imem_valid flow into the controller; imem_addr, ir,
//        rf_ra1/rf_ra2/rf_wa/rf_we, alu_ctl, busy/halted/illegal and
//        instr_count flow out. Modport slave = controller, master = environment.
interface multicycle_ctrl_if;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] ir;
  logic [4:0]  rf_ra1;
  logic [4:0]  rf_ra2;
  logic [4:0]  rf_wa;
  logic        rf_we;
  logic [1:0]  alu_ctl;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [15:0] instr_count;

  modport slave (
    input  start, imem_rdata, imem_valid,
    output imem_addr, ir, rf_ra1, rf_ra2, rf_wa, rf_we, alu_ctl,
           busy, halted, illegal, instr_count
  );

  modport master (
    output start, imem_rdata, imem_valid,
    input  imem_addr, ir, rf_ra1, rf_ra2, rf_wa, rf_we, alu_ctl,
           busy, halted, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Purpose: multicycle R-type controller (IDLE/FETCH/DECODE/EXEC/WB/HALT).
// Latency: 4 cycles per instruction (FETCH, DECODE, EXEC, WB) when imem is ready.
// Backpressure: imem_valid low holds FETCH (ir and PC frozen) indefinitely.
// Ports: clk, rst_n (synchronous, active-low) plus bus (slave modport):
//   start in, imem_addr/imem_rdata/imem_valid fetch side, ir and rf_* decode
//   fields, rf_we write pulse, alu_ctl, busy/halted/illegal status, instr_count.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] END_PC   = 32'h0000_0030
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0]  alu_q, alu_d;
  logic        rf_we_q, rf_we_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  logic [15:0] cnt_q, cnt_d;

  logic        legal;
  logic [1:0]  alu_dec;
  logic [31:0] pc_inc;

  // Supported set: opcode 0 with funct ADD(32) SUB(34) AND(36) OR(37).
  always_comb begin
    legal   = 1'b1;
    alu_dec = 2'b00;
    case (ir_q[5:0])
      6'd32:   alu_dec = 2'b10;
      6'd34:   alu_dec = 2'b11;
      6'd36:   alu_dec = 2'b00;
      6'd37:   alu_dec = 2'b01;
      default: legal   = 1'b0;
    endcase
    if (ir_q[31:26] != 6'd0) legal = 1'b0;
  end

  // Natural 32-bit wrap gives FFFF_FFFC -> 0.
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_d     = alu_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_valid) begin
          ir_d    = bus.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          alu_d   = alu_dec;
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        pc_d    = pc_inc;
        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        state_d = (pc_inc == END_PC) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (bus.start) begin
          pc_d      = RESET_PC;
          illegal_d = 1'b0;
          cnt_d     = 16'd0;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered from the next state so they line up
    // with the state they describe; rf_we is suppressed for a write to r0.
    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
               (state_d == S_EXEC)  || (state_d == S_WB);
    halted_d = (state_d == S_HALT);
    rf_we_d  = (state_d == S_WB) && (ir_d[15:11] != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      alu_q     <= 2'b00;
      rf_we_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_q     <= alu_d;
      rf_we_q   <= rf_we_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.ir          = ir_q;
  assign bus.rf_ra1      = ir_q[25:21];
  assign bus.rf_ra2      = ir_q[20:16];
  assign bus.rf_wa       = ir_q[15:11];
  assign bus.rf_we       = rf_we_q;
  assign bus.alu_ctl     = alu_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl_if wbus ();

  multicycle_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  multicycle_ctrl #(
    .RESET_PC(32'hFFFF_FFF8),
    .END_PC  (32'h0000_0004)
  ) u_wrap (.clk(clk), .rst_n(rst_n), .bus(wbus));

  localparam logic [31:0] ADD  = 32'h0109_8820; // add $s1,$t0,$t1
  localparam logic [31:0] SUB0 = 32'h014B_0022; // sub $0,$t2,$t3
  localparam logic [31:0] LW   = 32'h8D09_0000; // lw $t1,0($t0)
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  localparam logic [5:0] FN     [4] = '{6'd32, 6'd34, 6'd36, 6'd37};
  localparam logic [1:0] ALU_OF [4] = '{2'd2, 2'd3, 2'd0, 2'd1};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Directed vector: inputs {rst_n,start,imem_valid}, rdata; expected
  // flags {busy,halted,illegal,rf_we}, pc, count, ir, alu_ctl after the edge.
  typedef struct packed {
    logic [2:0]  in;
    logic [31:0] rdata;
    logic [3:0]  flg;
    logic [31:0] pc;
    logic [15:0] cnt;
    logic [31:0] ir;
    logic [1:0]  alu;
  } vec_t;

  // One expected cycle of a program run, derived from an instruction timeline.
  typedef struct packed {
    logic        busy, halted, ill, we, fetch, vld, ir_k, alu_k;
    logic [31:0] pc;
    logic [15:0] cnt;
    logic [31:0] ir;
    logic [1:0]  alu;
    logic [31:0] rdata;
  } cyc_t;

  vec_t tbl [24];

  task automatic run_table();
    vec_t t;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      t = tbl[i];
      {rst_n, bus.start, bus.imem_valid} = t.in;
      bus.imem_rdata = t.rdata;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {bus.busy, bus.halted, bus.illegal, bus.rf_we, bus.imem_addr, bus.instr_count,
           bus.ir, bus.alu_ctl, bus.rf_ra1, bus.rf_ra2, bus.rf_wa},
          {t.flg, t.pc, t.cnt, t.ir, t.alu, t.ir[25:21], t.ir[20:16], t.ir[15:11]});
    end
  endtask

  // Random 12-word program; instruction k waits wt[k] cycles for imem_valid.
  // Expected behaviour per cycle comes from an instruction-level timeline:
  // fetch occupies wt+1 cycles, then decode, exec, write-back.
  task automatic run_prog(input bit fixed, input int run);
    logic [31:0] prog [12];
    logic [1:0]  alu  [12];
    int          wt   [12];
    int          ill_idx, sel, k_end;
    logic [31:0] fpc;
    logic [15:0] fcnt;
    logic        fill;
    cyc_t        tl [$];
    cyc_t        e;

    ill_idx = -1;
    if (!fixed && $urandom_range(0, 2) == 0) ill_idx = $urandom_range(0, 11);
    for (int k = 0; k < 12; k++) begin
      sel = fixed ? (k % 4) : $urandom_range(0, 3);
      prog[k] = {6'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 5'd0, FN[sel]};
      alu[k] = ALU_OF[sel];
      if (k == ill_idx) begin
        if ($urandom_range(0, 1) == 1) prog[k][31:26] = 6'b100011;
        else                           prog[k][5:0]   = 6'd33;
      end
      wt[k] = fixed ? 0 : $urandom_range(0, 3);
    end

    fpc = 32'd48; fcnt = 16'd12; fill = 1'b0; k_end = 11;
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j <= wt[k]; j++) begin
        e = '0; e.busy = 1'b1; e.fetch = 1'b1; e.vld = (j == wt[k]);
        e.pc = 32'(4 * k); e.cnt = 16'(k); e.rdata = prog[k];
        if (k > 0) begin e.ir_k = 1'b1; e.ir = prog[k-1]; end
        tl.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.pc = 32'(4 * k); e.cnt = 16'(k);
      e.ir_k = 1'b1; e.ir = prog[k];
      tl.push_back(e);
      if (k == ill_idx) begin
        fpc = 32'(4 * k); fcnt = 16'(k); fill = 1'b1; k_end = k;
        break;
      end
      e.alu_k = 1'b1; e.alu = alu[k];
      tl.push_back(e);
      e.we = (prog[k][15:11] != 5'd0);
      tl.push_back(e);
    end
    for (int j = 0; j < 3; j++) begin
      e = '0; e.halted = 1'b1; e.ill = fill; e.pc = fpc; e.cnt = fcnt;
      e.ir_k = 1'b1; e.ir = prog[k_end];
      tl.push_back(e);
    end

    @(negedge clk);
    bus.start = 1'b1;
    bus.imem_valid = 1'($urandom_range(0, 1));
    bus.imem_rdata = $urandom;
    @(posedge clk);
    for (int c = 0; c < tl.size(); c++) begin
      @(negedge clk);
      e = tl[c];
      chk($sformatf("run%0d_c%0d_ctl", run, c),
          {bus.busy, bus.halted, bus.illegal, bus.rf_we, bus.imem_addr, bus.instr_count},
          {e.busy, e.halted, e.ill, e.we, e.pc, e.cnt});
      if (e.ir_k)  chk($sformatf("run%0d_c%0d_ir", run, c), bus.ir, e.ir);
      if (e.alu_k) chk($sformatf("run%0d_c%0d_alu", run, c), bus.alu_ctl, e.alu);
      // start while busy and imem_valid outside fetch must both be ignored.
      bus.start = e.busy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (e.fetch) begin
        bus.imem_valid = e.vld;
        bus.imem_rdata = e.vld ? e.rdata : $urandom;
      end else begin
        bus.imem_valid = 1'($urandom_range(0, 1));
        bus.imem_rdata = $urandom;
      end
      @(posedge clk);
    end
  endtask

  task automatic run_wrap();
    logic [48:0] exp;
    @(negedge clk);
    rst_n = 1'b0; bus.start = 1'b0; bus.imem_valid = 1'b0;
    wbus.start = 1'b0; wbus.imem_valid = 1'b1; wbus.imem_rdata = ADD;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; wbus.start = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      wbus.start = 1'b0;
      exp = 'x;
      case (c)
        0:  exp = {1'b0, 32'hFFFF_FFF8, 16'd0};
        4:  exp = {1'b0, 32'hFFFF_FFFC, 16'd1};
        8:  exp = {1'b0, 32'h0000_0000, 16'd2};
        12: exp = {1'b1, 32'h0000_0004, 16'd3};
        default: ;
      endcase
      if (c % 4 == 0)
        chk($sformatf("wrap_c%0d", c), {wbus.halted, wbus.imem_addr, wbus.instr_count}, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.imem_valid = 1'b0; bus.imem_rdata = 32'd0;
    wbus.start = 1'b0; wbus.imem_valid = 1'b0; wbus.imem_rdata = 32'd0;

    //            {rst,start,vld} rdata  {busy,halt,ill,we} pc     cnt    ir    alu
    tbl[0]  = {3'b011, ADD,  4'b0000, 32'd0, 16'd0, 32'd0, 2'd0}; // reset beats start
    tbl[1]  = {3'b100, JUNK, 4'b0000, 32'd0, 16'd0, 32'd0, 2'd0}; // IDLE holds
    tbl[2]  = {3'b111, ADD,  4'b1000, 32'd0, 16'd0, 32'd0, 2'd0}; // FETCH
    tbl[3]  = {3'b101, ADD,  4'b1000, 32'd0, 16'd0, ADD,   2'd0}; // DECODE
    tbl[4]  = {3'b100, JUNK, 4'b1000, 32'd0, 16'd0, ADD,   2'd2}; // EXEC
    tbl[5]  = {3'b111, JUNK, 4'b1001, 32'd0, 16'd0, ADD,   2'd2}; // WB, rf_we
    tbl[6]  = {3'b110, JUNK, 4'b1000, 32'd4, 16'd1, ADD,   2'd2}; // FETCH
    tbl[7]  = {3'b110, JUNK, 4'b1000, 32'd4, 16'd1, ADD,   2'd2}; // stall 1
    tbl[8]  = {3'b100, JUNK, 4'b1000, 32'd4, 16'd1, ADD,   2'd2}; // stall 2
    tbl[9]  = {3'b100, JUNK, 4'b1000, 32'd4, 16'd1, ADD,   2'd2}; // stall 3
    tbl[10] = {3'b101, SUB0, 4'b1000, 32'd4, 16'd1, SUB0,  2'd2}; // DECODE
    tbl[11] = {3'b100, JUNK, 4'b1000, 32'd4, 16'd1, SUB0,  2'd3}; // EXEC
    tbl[12] = {3'b100, JUNK, 4'b1000, 32'd4, 16'd1, SUB0,  2'd3}; // WB, rd=0
    tbl[13] = {3'b100, JUNK, 4'b1000, 32'd8, 16'd2, SUB0,  2'd3}; // FETCH
    tbl[14] = {3'b101, LW,   4'b1000, 32'd8, 16'd2, LW,    2'd3}; // DECODE lw
    tbl[15] = {3'b111, ADD,  4'b0110, 32'd8, 16'd2, LW,    2'd3}; // HALT illegal
    tbl[16] = {3'b101, ADD,  4'b0110, 32'd8, 16'd2, LW,    2'd3}; // HALT holds
    tbl[17] = {3'b110, JUNK, 4'b1000, 32'd0, 16'd0, LW,    2'd3}; // restart
    tbl[18] = {3'b101, ADD,  4'b1000, 32'd0, 16'd0, ADD,   2'd3}; // DECODE
    tbl[19] = {3'b100, JUNK, 4'b1000, 32'd0, 16'd0, ADD,   2'd2}; // EXEC
    tbl[20] = {3'b100, JUNK, 4'b1001, 32'd0, 16'd0, ADD,   2'd2}; // WB
    tbl[21] = {3'b011, ADD,  4'b0000, 32'd0, 16'd0, 32'd0, 2'd0}; // reset in WB
    tbl[22] = {3'b011, ADD,  4'b0000, 32'd0, 16'd0, 32'd0, 2'd0}; // start ignored
    tbl[23] = {3'b100, JUNK, 4'b0000, 32'd0, 16'd0, 32'd0, 2'd0}; // IDLE

    run_table();
    run_prog(1'b1, 0);
    for (int r = 1; r <= 20; r++) run_prog(1'b0, r);
    run_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
